// File: rtl/mem_access_pkg.sv
// Shared size/state encodings and big-endian lane positions for the load/store front-end.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWr,
    StResp
  } state_e;

  // Right-shift that brings a big-endian lane down to bit 0.
  localparam logic [4:0] LANE_SHIFT_0 = 5'd24;
  localparam logic [4:0] LANE_SHIFT_1 = 5'd16;
  localparam logic [4:0] LANE_SHIFT_2 = 5'd8;
  localparam logic [4:0] LANE_SHIFT_3 = 5'd0;

  function automatic logic [4:0] lane_shift(input logic [1:0] off, input logic [1:0] size);
    lane_shift = 5'd0;
    case (size)
      SIZE_BYTE: begin
        case (off)
          2'd0:    lane_shift = LANE_SHIFT_0;
          2'd1:    lane_shift = LANE_SHIFT_1;
          2'd2:    lane_shift = LANE_SHIFT_2;
          default: lane_shift = LANE_SHIFT_3;
        endcase
      end
      SIZE_HALF: lane_shift = off[1] ? LANE_SHIFT_3 : LANE_SHIFT_1;
      default:   lane_shift = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane extract (with sign/zero extension) and lane merge for a RAM word.
module byte_lane_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_ram_q,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [1:0]            i_offset,
  input  logic [1:0]            i_size,
  input  logic                  i_signed,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic [DATA_WIDTH-1:0] o_merge_data
);

  logic [4:0]            w_shift;
  logic [DATA_WIDTH-1:0] w_lane;
  logic [DATA_WIDTH-1:0] w_mask;

  assign w_shift = lane_shift(i_offset, i_size);
  assign w_lane  = i_ram_q >> w_shift;

  always_comb begin
    o_load_data = i_ram_q;
    w_mask      = '1;
    case (i_size)
      SIZE_BYTE: begin
        o_load_data = {{(DATA_WIDTH-8){i_signed & w_lane[7]}}, w_lane[7:0]};
        w_mask      = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << w_shift;
      end
      SIZE_HALF: begin
        o_load_data = {{(DATA_WIDTH-16){i_signed & w_lane[15]}}, w_lane[15:0]};
        w_mask      = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << w_shift;
      end
      default: begin
        o_load_data = i_ram_q;
        w_mask      = '1;
      end
    endcase
  end

  assign o_merge_data = (i_ram_q & ~w_mask) | ((i_wdata << w_shift) & w_mask);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end for single_port_ram; sub-word stores use read-modify-write.
// Define MEM_ACCESS_HIT_BUF_EN to add a one-entry last-word buffer.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_signed,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_q
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [1:0]            r_offset;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_data;

  logic                  w_accept;
  logic                  w_req_err;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_blu_q;
  logic [DATA_WIDTH-1:0] w_blu_wdata;
  logic [1:0]            w_blu_offset;
  logic [1:0]            w_blu_size;
  logic                  w_blu_signed;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_merge;

  assign w_accept  = (r_state == StIdle) && i_req_valid;
  assign w_req_err = (i_req_size == 2'b11) ||
                     ((i_req_size == SIZE_HALF) && i_req_addr[0]) ||
                     ((i_req_size == SIZE_WORD) && (i_req_addr[1:0] != 2'b00));

`ifdef MEM_ACCESS_HIT_BUF_EN
  logic                  r_buf_vld;
  logic [ADDR_WIDTH-3:0] r_buf_addr;
  logic [DATA_WIDTH-1:0] r_buf_data;

  assign w_hit = r_buf_vld && (r_buf_addr == i_req_addr[ADDR_WIDTH-1:2]);

  // In IDLE the lane unit serves a buffer hit; elsewhere it serves the RAM read.
  assign w_blu_q      = (r_state == StIdle) ? r_buf_data      : i_ram_q;
  assign w_blu_wdata  = (r_state == StIdle) ? i_req_wdata     : r_wdata;
  assign w_blu_offset = (r_state == StIdle) ? i_req_addr[1:0] : r_offset;
  assign w_blu_size   = (r_state == StIdle) ? i_req_size      : r_size;
  assign w_blu_signed = (r_state == StIdle) ? i_req_signed    : r_signed;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_buf_vld  <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
    end else if (r_state == StRdData) begin
      r_buf_vld  <= 1'b1;
      r_buf_addr <= r_ram_addr[ADDR_WIDTH-1:2];
      r_buf_data <= i_ram_q;
    end else if (r_state == StWr) begin
      r_buf_vld  <= 1'b1;
      r_buf_addr <= r_ram_addr[ADDR_WIDTH-1:2];
      r_buf_data <= r_ram_data;
    end
  end
`else
  assign w_hit        = 1'b0;
  assign w_blu_q      = i_ram_q;
  assign w_blu_wdata  = r_wdata;
  assign w_blu_offset = r_offset;
  assign w_blu_size   = r_size;
  assign w_blu_signed = r_signed;
`endif

  byte_lane_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_byte_lane_unit (
    .i_ram_q     (w_blu_q),
    .i_wdata     (w_blu_wdata),
    .i_offset    (w_blu_offset),
    .i_size      (w_blu_size),
    .i_signed    (w_blu_signed),
    .o_load_data (w_load),
    .o_merge_data(w_merge)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          if (w_req_err)                                  w_state_nxt = StResp;
          else if (i_req_we && (i_req_size == SIZE_WORD)) w_state_nxt = StWr;
          else if (w_hit)                                 w_state_nxt = i_req_we ? StWr : StResp;
          else                                            w_state_nxt = StRdAddr;
        end
      end
      StRdAddr: w_state_nxt = StRdData;
      StRdData: w_state_nxt = r_we ? StWr : StResp;
      StWr:     w_state_nxt = StResp;
      StResp:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_we        <= 1'b0;
      r_size      <= SIZE_BYTE;
      r_signed    <= 1'b0;
      r_offset    <= 2'b00;
      r_wdata     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we        <= i_req_we;
        r_size      <= i_req_size;
        r_signed    <= i_req_signed;
        r_offset    <= i_req_addr[1:0];
        r_wdata     <= i_req_wdata;
        r_rsp_err   <= w_req_err;
        r_rsp_rdata <= '0;
        if (!w_req_err) begin
          r_ram_addr <= {i_req_addr[ADDR_WIDTH-1:2], 2'b00};
          if (i_req_we && (i_req_size == SIZE_WORD)) r_ram_data <= i_req_wdata;
          if (w_hit) begin
            if (i_req_we) r_ram_data  <= w_merge;
            else          r_rsp_rdata <= w_load;
          end
        end
      end else if (r_state == StRdData) begin
        if (r_we) r_ram_data  <= w_merge;
        else      r_rsp_rdata <= w_load;
      end
    end
  end

  assign o_req_ready = (r_state == StIdle);
  assign o_rsp_valid = (r_state == StResp);
  assign o_ram_we    = (r_state == StWr);
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_data  = r_ram_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit against a big-endian byte-array memory model.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_data;
  logic        ram_we;
  logic [31:0] ram_q;

  mem_access_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_size  (req_size),
    .i_req_signed(req_signed),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_ram_addr  (ram_addr),
    .o_ram_data  (ram_data),
    .o_ram_we    (ram_we),
    .i_ram_q     (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM with registered read address; untouched words read from init_mem.
  logic [31:0] init_mem [0:15];
  logic [31:0] ram      [0:15];
  logic        written  [0:15];
  logic [3:0]  ram_areg;
  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr[5:2]]     <= ram_data;
      written[ram_addr[5:2]] <= 1'b1;
    end
    ram_areg <= ram_addr[5:2];
  end
  assign ram_q = (written[ram_areg] === 1'b1) ? ram[ram_areg] : init_mem[ram_areg];

  // Reference memory: 64 bytes, big-endian.
  logic [7:0] mb [0:63];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  exp_t q[$];
  wr_t  wq[$];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [5:0] a);
    logic [5:0] b;
    b = {a[5:2], 2'b00};
    return {mb[b], mb[b + 6'd1], mb[b + 6'd2], mb[b + 6'd3]};
  endfunction

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [5:0] addr, input logic [31:0] wdata, input bit commit);
    exp_t        e;
    wr_t         w;
    int          guard;
    int          nb;
    logic        err;
    logic [31:0] res;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = {26'd0, addr};
    req_wdata  = wdata;
    guard = 0;
    while (!req_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: req_ready stayed 0 for addr %h", addr);
      req_valid = 1'b0;
      return;
    end
    err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    e.err   = err;
    e.rdata = 32'd0;
    e.acc   = cyc + 1;
    if (err) begin
      e.lat = 0;
    end else if (!we) begin
      res = 32'd0;
      for (int i = 0; i < nb; i++) res = (res << 8) | {24'd0, mb[addr + 6'(i)]};
      if (sgn && nb < 4 && res[8*nb-1]) res = res | ~((32'd1 << (8 * nb)) - 32'd1);
      e.rdata = res;
      e.lat   = 2;
    end else begin
      e.lat = (nb == 4) ? 1 : 3;
      if (commit) begin
        for (int i = 0; i < nb; i++) mb[addr + 6'(i)] = wdata[8*(nb-1-i) +: 8];
        w.addr = {26'd0, addr[5:2], 2'b00};
        w.data = model_word(addr);
        wq.push_back(w);
      end
    end
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Monitor: compares every response and RAM write against the queued expectations.
  initial begin
    exp_t e;
    wr_t  w;
    logic busy;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy = (q.size() > 0) && (q[0].acc <= cyc);
        chk("req_ready", {31'd0, req_ready}, {31'd0, !busy});
        if (ram_we) begin
          if (wq.size() == 0) begin
            chk("unexpected_ram_we", {31'd0, ram_we}, 32'd0);
          end else begin
            w = wq.pop_front();
            chk("ram_addr", ram_addr, w.addr);
            chk("ram_data", ram_data, w.data);
          end
        end
        if (rsp_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_rsp_valid", {31'd0, rsp_valid}, 32'd0);
          end else begin
            e = q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  a;
    logic [1:0]  sz;
    logic        we;
    logic        sg;
    logic [31:0] wd;
    int          guard;
    for (int i = 0; i < 16; i++) begin
      init_mem[i] = (i == 4) ? 32'h8899AABB : $urandom;
      for (int b = 0; b < 4; b++) mb[i*4 + b] = init_mem[i][8*(3-b) +: 8];
    end
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_ram_we", {31'd0, ram_we}, 32'd0);
    chk("reset_ram_addr", ram_addr, 32'd0);
    chk("reset_ram_data", ram_data, 32'd0);

    // Directed sequence
    issue(1'b0, 2'b10, 1'b0, 6'h10, 32'd0, 1'b1); idle();          // lw 0x10
    issue(1'b0, 2'b00, 1'b1, 6'h11, 32'd0, 1'b1); idle();          // lb 0x11
    issue(1'b0, 2'b00, 1'b0, 6'h13, 32'd0, 1'b1); idle();          // lbu 0x13
    issue(1'b0, 2'b01, 1'b1, 6'h12, 32'd0, 1'b1); idle();          // lh 0x12
    issue(1'b1, 2'b00, 1'b0, 6'h12, 32'h000000CC, 1'b1); idle();   // sb 0x12
    issue(1'b0, 2'b10, 1'b0, 6'h10, 32'd0, 1'b1); idle();          // lw 0x10
    issue(1'b1, 2'b01, 1'b0, 6'h13, 32'h00001234, 1'b1); idle();   // sh misaligned
    issue(1'b1, 2'b10, 1'b0, 6'h12, 32'hDEADBEEF, 1'b1); idle();   // sw misaligned

    // Sub-word store cut by reset in RD_DATA: nothing may be written
    issue(1'b1, 2'b00, 1'b0, 6'h10, 32'h00000055, 1'b0);
    idle();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_ram_we", {31'd0, ram_we}, 32'd0);
    q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 6'h10, 32'd0, 1'b1); idle();          // word unchanged

    // Back-to-back loads with req_valid held high
    issue(1'b0, 2'b10, 1'b0, 6'h10, 32'd0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 6'h14, 32'd0, 1'b1);
    idle();

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      a  = 6'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      issue(we, sz, sg, a, wd, 1'b1);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    guard = 0;
    while ((q.size() > 0 || wq.size() > 0) && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    chk("rsp_queue_drained", 32'(q.size()), 32'd0);
    chk("wr_queue_drained", 32'(wq.size()), 32'd0);

    // Final sweep: every word in RAM must equal the model
    for (int i = 0; i < 16; i++) begin
      chk("ram_contents", (written[i] === 1'b1) ? ram[i] : init_mem[i], model_word(6'(i * 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end between the multicycle MIPS datapath and single_port_ram.
- Accepts one byte, halfword or word request at a time over a valid/ready handshake and drives the RAM's data/addr/we.
- Sub-word stores use read-modify-write, because the RAM has no byte enables.
- Sub-word loads are extracted and sign- or zero-extended from the RAM's registered-address read port.
- Byte order is big-endian.

Parameters:
DATA_WIDTH, 32, data width of requests and RAM words
ADDR_WIDTH, 32, CPU byte-address width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle; request accepted on clk edge when req_valid&req_ready
req_we  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=halfword, 10=word, 11=illegal
req_signed  in  1  loads: 1=sign-extend, 0=zero-extend
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-justified
rsp_valid  out  1  one-cycle pulse, request complete
rsp_rdata  out  DATA_WIDTH  load result, valid with rsp_valid
rsp_err  out  1  misaligned/illegal request flag, valid with rsp_valid
ram_addr  out  ADDR_WIDTH  word-aligned address {req_addr[ADDR_WIDTH-1:2],2'b00}
ram_data  out  DATA_WIDTH  RAM write data
ram_we  out  1  RAM write enable
ram_q  in  DATA_WIDTH  RAM read data, valid the cycle after ram_addr is sampled

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_we=0, ram_addr=0, ram_data=0.
- Reset takes effect immediately at any state; a pending store is dropped and no ram_we pulse is issued.
- Request fields are captured at acceptance. req_ready is 0 in every state except IDLE.
- States: IDLE, RD_ADDR, RD_DATA, WR, RESP.
- Cycle numbering: acceptance edge is E0, each following edge is E1, E2, and so on.
- IDLE transitions on accept:
  - misaligned/illegal -> RESP;
  - word store -> WR;
  - any load or sub-word store -> RD_ADDR.
- RD_ADDR: ram_addr driven, ram_we=0; RAM samples the address at the next edge -> RD_DATA.
- RD_DATA: ram_q valid.
  - Load: register the extracted result into rsp_rdata -> RESP.
  - Sub-word store: register the merged word into ram_data -> WR.
- WR: ram_we=1 for exactly this one cycle; the write occurs at the following edge -> RESP.
- RESP: rsp_valid=1 for one cycle -> IDLE. A new request is accepted no earlier than the edge after RESP.
- Latencies (rsp_valid high in cycle after):
  - load: E2;
  - word store: E1;
  - sub-word store: E3;
  - error: E0.
- Byte lanes, by addr[1:0]:
  - byte offsets 0/1/2/3 map to bits 31:24 / 23:16 / 15:8 / 7:0;
  - halfword offset 0 -> 31:16, offset 2 -> 15:0.
- Merge replaces only the addressed lane with the low bits of req_wdata; other lanes keep ram_q.
- Misaligned/illegal cases:
  - halfword with addr[0]=1, word with addr[1:0]!=0, or size=11;
  - no RAM access (ram_we stays 0);
  - rsp_err=1, rsp_rdata=0.
- rsp_err=0 on all legal responses. rsp_rdata is 0 for stores.
- ram_addr holds its last value in IDLE. ram_data is don't-care when ram_we=0.

Optional Feature:
MEM_ACCESS_HIT_BUF_EN: one-entry last-word buffer holding a valid bit, word address and data.
- Filled on every RD_DATA, and updated with the written word in WR.
- A load that hits the buffer goes IDLE -> RESP with data from the buffer, so rsp_valid is high in the cycle after E0.
- A sub-word store that hits skips RD_ADDR/RD_DATA and merges from the buffer straight into WR.
- The valid bit is cleared on reset.
- Without the macro there is no buffer, and all timing is as above.

Decomposition:
- mem_access_pkg holds:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - state encodings;
  - the lane-offset constants.
- Sub-module byte_lane_unit is combinational:
  - extract: ram_q, offset, size, signed -> load data;
  - merge: ram_q, wdata, offset, size -> write word.

Test Plan:
- Word 0x10 preloaded to 0x8899AABB; lw 0x10 -> rsp_valid in cycle after E2, rsp_rdata=0x8899AABB, rsp_err=0, ram_we never 1.
- lb signed 0x11 -> 0xFFFFFF99; lbu 0x13 -> 0x000000BB; lh signed 0x12 -> 0xFFFFAABB.
- sb 0x12, wdata 0x000000CC -> single ram_we cycle with ram_data=0x8899CCBB, ram_addr=0x10; a following lw 0x10 returns 0x8899CCBB.
- sh 0x13 -> rsp_valid in cycle after E0, rsp_err=1, rsp_rdata=0, ram_we never 1; sw 0x12 gives the same result.
- sb 0x10 with reset asserted during RD_DATA -> no ram_we pulse, word unchanged, req_ready=1 immediately, rsp_valid=0.
- req_valid held high for two back-to-back lw -> req_ready=0 from E0 until IDLE, exactly two rsp_valid pulses, no lost or duplicated request.
